seq_mult_param: RTL and testbench

Parametrised iterative shift-add multiplier: one multiplier bit per clock, WIDTH iterations per operation. It supports unsigned, signed two's-complement and carry-less (GF(2), XOR-accumulate) modes. A start/busy/done handshake wraps the block, and the product is registered and held until the next completion. It sits in the arithmetic datapath as the drop-in generalised replacement for the fixed 16-bit controller+datapath multiplier pair.

---
 rtl/seq_mult_param.sv | 135 +++++++++++++
 tb/tb_seq_mult_param.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_param.sv
// -----------------------------------------------------------------------------
// seq_mult_param
// Iterative shift-add multiplier that consumes one multiplier bit per clock,
// taking WIDTH iterations per operation. It has three modes: unsigned, signed
// two's-complement and carry-less (GF(2), XOR-accumulate). A start/busy/done
// handshake wraps the block. The product is registered and is held until the
// next completion.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        operation request, sampled only when not busy
//   mode         00 unsigned, 01 signed, 10 carry-less, 11 treated as 00
//   multiplicand operand A, sampled with start
//   multiplier   operand B, sampled with start
//   busy         high while an operation is in progress
//   done         one-cycle pulse when product is updated
//   product      registered 2*WIDTH-bit result
// -----------------------------------------------------------------------------
module seq_mult_param #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_UNS = 2'd0,
    OP_SGN = 2'd1,
    OP_CLM = 2'd2
  } op_t;

  state_t            state;
  op_t               op_r;
  logic [WIDTH-1:0]  mcand;
  logic [WIDTH-1:0]  mq;
  logic [WIDTH:0]    acc;
  logic [CW-1:0]     count;

  logic [WIDTH:0]    addend;
  logic [WIDTH:0]    acc_sum;
  logic              fill;
  logic [WIDTH:0]    acc_nxt;
  logic [WIDTH-1:0]  mq_nxt;

  function automatic op_t decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return OP_SGN;
      2'b10:   return OP_CLM;
      default: return OP_UNS;
    endcase
  endfunction

  // One iteration: conditional add/sub/xor into acc, then a one-bit right shift
  // of {acc,mq}. Signed mode subtracts on the last bit (weight -2^(W-1)) and
  // shifts arithmetically; the other modes shift in zero.
  always_comb begin
    addend  = (op_r == OP_SGN) ? {mcand[WIDTH-1], mcand} : {1'b0, mcand};
    acc_sum = acc;
    if (mq[0]) begin
      case (op_r)
        OP_CLM:  acc_sum = {1'b0, acc[WIDTH-1:0] ^ mcand};
        OP_SGN:  acc_sum = (count == LAST) ? (acc - addend) : (acc + addend);
        default: acc_sum = acc + addend;
      endcase
    end
    fill    = (op_r == OP_SGN) ? acc_sum[WIDTH] : 1'b0;
    acc_nxt = {fill, acc_sum[WIDTH:1]};
    mq_nxt  = {acc_sum[0], mq[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      op_r    <= OP_UNS;
      mcand   <= '0;
      mq      <= '0;
      acc     <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= multiplicand;
            mq    <= multiplier;
            op_r  <= decode_mode(mode);
            acc   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          mq    <= mq_nxt;
          count <= count + CW'(1);
          if (count == LAST) begin
            product <= {acc_nxt[WIDTH-1:0], mq_nxt};
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_param.sv
// -----------------------------------------------------------------------------
// tb_seq_mult_param
// Self-checking bench for seq_mult_param. There are three instances:
//   - WIDTH=16 runs the directed cases and the reset-abort case.
//   - WIDTH=8 and WIDTH=32 run randomised operations against a reference model.
// Expected results and start times are queued when a request is driven. They
// are popped when the matching done pulse appears.
// -----------------------------------------------------------------------------
module tb_seq_mult_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] exp;
    longint       t0;
  } item_t;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] got,
                          input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model(input int w, input logic [1:0] m,
                                         input logic [63:0] a,
                                         input logic [63:0] b);
    logic [127:0] x, y, r, mask;
    mask = (w == 64) ? '1 : ((128'd1 << (2 * w)) - 128'd1);
    x = {64'd0, a};
    y = {64'd0, b};
    r = '0;
    case (m)
      2'b01: begin
        for (int i = w; i < 128; i++) begin
          x[i] = x[w-1];
          y[i] = y[w-1];
        end
        r = x * y;
      end
      2'b10: begin
        for (int i = 0; i < w; i++)
          if (y[i]) r = r ^ (x << i);
      end
      default: r = x * y;
    endcase
    return r & mask;
  endfunction

  function automatic logic [63:0] pick(input int w);
    logic [63:0] msk, v;
    msk = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = 64'd1 << (w - 1);
      default: v = {$urandom, $urandom};
    endcase
    return v & msk;
  endfunction

  // ---------------- WIDTH=16 instance ----------------
  logic        rst16 = 1'b0, st16 = 1'b0;
  logic [1:0]  md16 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16;
  logic [31:0] prod16;
  item_t       q16[$];
  int          bc16 = 0, dc16 = 0;
  logic [31:0] last16 = '0;

  seq_mult_param #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(rst16), .start(st16), .mode(md16),
    .multiplicand(a16), .multiplier(b16),
    .busy(busy16), .done(done16), .product(prod16)
  );

  // ---------------- WIDTH=8 / WIDTH=32 instances ----------------
  logic        rst_n = 1'b0;
  logic        st8 = 1'b0, st32 = 1'b0;
  logic [1:0]  md8 = '0, md32 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy8, done8, busy32, done32;
  logic [15:0] prod8;
  logic [63:0] prod32;
  item_t       q8[$], q32[$];
  int          bc8 = 0, bc32 = 0;

  seq_mult_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst_n), .start(st8), .mode(md8),
    .multiplicand(a8), .multiplier(b8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  seq_mult_param #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(rst_n), .start(st32), .mode(md32),
    .multiplicand(a32), .multiplier(b32),
    .busy(busy32), .done(done32), .product(prod32)
  );

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    item_t it;
    if (!rst16) begin
      bc16   = 0;
      last16 = prod16;
    end else begin
      if (busy16) bc16++;
      if (done16) begin
        dc16++;
        check_eq("busy_at_done16", 128'(busy16), 128'd0);
        check_eq("busy_len16", 128'(bc16), 128'd16);
        bc16 = 0;
        if (q16.size() == 0) check_eq("spurious_done16", 128'd1, 128'd0);
        else begin
          it = q16.pop_front();
          check_eq("prod16", 128'(prod16), it.exp);
          check_eq("lat16", 128'(cyc - it.t0), 128'd16);
        end
      end else begin
        check_eq("hold16", 128'(prod16), 128'(last16));
      end
      last16 = prod16;
    end
  end

  always @(negedge clk) begin
    item_t it;
    if (!rst_n) bc8 = 0;
    else begin
      if (busy8) bc8++;
      if (done8) begin
        check_eq("busy_len8", 128'(bc8), 128'd8);
        bc8 = 0;
        if (q8.size() == 0) check_eq("spurious_done8", 128'd1, 128'd0);
        else begin
          it = q8.pop_front();
          check_eq("prod8", 128'(prod8), it.exp);
          check_eq("lat8", 128'(cyc - it.t0), 128'd8);
        end
      end
    end
  end

  always @(negedge clk) begin
    item_t it;
    if (!rst_n) bc32 = 0;
    else begin
      if (busy32) bc32++;
      if (done32) begin
        check_eq("busy_len32", 128'(bc32), 128'd32);
        bc32 = 0;
        if (q32.size() == 0) check_eq("spurious_done32", 128'd1, 128'd0);
        else begin
          it = q32.pop_front();
          check_eq("prod32", 128'(prod32), it.exp);
          check_eq("lat32", 128'(cyc - it.t0), 128'd32);
        end
      end
    end
  end

  // ---------------- WIDTH=16 drivers ----------------
  task automatic wait_done16(input string tag);
    int k;
    k = 0;
    while (!done16 && k < 24) begin
      @(negedge clk);
      k++;
    end
    if (!done16) check_eq(tag, 128'd0, 128'd1);
  endtask

  task automatic drive16(input logic [1:0] m, input logic [15:0] a,
                         input logic [15:0] b);
    st16 = 1'b1;
    md16 = m;
    a16  = a;
    b16  = b;
  endtask

  task automatic op16(input logic [1:0] m, input logic [15:0] a,
                      input logic [15:0] b, input logic [31:0] exp);
    drive16(m, a, b);
    q16.push_back('{exp: 128'(exp), t0: cyc + 1});
    @(negedge clk);
    st16 = 1'b0;
    wait_done16("timeout16");
    @(negedge clk);
  endtask

  initial begin
    int dc0;
    #1;
    check_eq("rst_busy16", 128'(busy16), 128'd0);
    check_eq("rst_done16", 128'(done16), 128'd0);
    check_eq("rst_prod16", 128'(prod16), 128'd0);
    check_eq("rst_prod8", 128'(prod8), 128'd0);
    check_eq("rst_prod32", 128'(prod32), 128'd0);
    repeat (2) @(negedge clk);
    #2;
    rst16 = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);

    fork
      begin : directed16
        op16(2'b00, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        op16(2'b01, 16'hFFFF, 16'hFFFF, 32'h00000001);
        op16(2'b01, 16'h8000, 16'h8000, 32'h40000000);
        op16(2'b01, 16'h0003, 16'hFFFE, 32'hFFFFFFFA);
        op16(2'b10, 16'h0003, 16'h0003, 32'h00000005);
        op16(2'b10, 16'hFFFF, 16'hFFFF, 32'h55555555);
        op16(2'b11, 16'h0002, 16'h0003, 32'h00000006);

        // A start during RUN is ignored. A start in the DONE cycle is accepted.
        dc0 = dc16;
        drive16(2'b00, 16'd5, 16'd7);
        q16.push_back('{exp: 128'd35, t0: cyc + 1});
        @(negedge clk);
        st16 = 1'b0;
        repeat (4) @(negedge clk);
        drive16(2'b00, 16'd9, 16'd9);
        @(negedge clk);
        st16 = 1'b0;
        wait_done16("timeout16_b2b_a");
        drive16(2'b00, 16'd2, 16'd3);
        q16.push_back('{exp: 128'd6, t0: cyc + 1});
        @(negedge clk);
        st16 = 1'b0;
        wait_done16("timeout16_b2b_b");
        repeat (20) @(negedge clk);
        check_eq("done_count16", 128'(dc16 - dc0), 128'd2);

        // Reset in cycle 8 of RUN discards the operation.
        dc0 = dc16;
        drive16(2'b00, 16'h1234, 16'h5678);
        @(negedge clk);
        st16 = 1'b0;
        repeat (7) @(negedge clk);
        #2;
        rst16 = 1'b0;
        #1;
        check_eq("abort_busy16", 128'(busy16), 128'd0);
        check_eq("abort_done16", 128'(done16), 128'd0);
        check_eq("abort_prod16", 128'(prod16), 128'd0);
        repeat (2) @(negedge clk);
        #2;
        rst16 = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("abort_no_done16", 128'(dc16 - dc0), 128'd0);
        check_eq("q16_drained", 128'(q16.size()), 128'd0);
      end

      begin : rand8
        logic [63:0] a, b;
        logic [1:0]  m;
        int          k;
        for (int n = 0; n < 600; n++) begin
          m = 2'($urandom_range(0, 3));
          a = pick(8);
          b = pick(8);
          st8 = 1'b1; md8 = m; a8 = a[7:0]; b8 = b[7:0];
          q8.push_back('{exp: model(8, m, a, b), t0: cyc + 1});
          @(negedge clk);
          st8 = 1'b0;
          k = 0;
          while (!done8 && k < 16) begin
            @(negedge clk);
            k++;
          end
          if (!done8) check_eq("timeout8", 128'd0, 128'd1);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check_eq("q8_drained", 128'(q8.size()), 128'd0);
      end

      begin : rand32
        logic [63:0] a, b;
        logic [1:0]  m;
        int          k;
        for (int n = 0; n < 600; n++) begin
          m = 2'($urandom_range(0, 3));
          a = pick(32);
          b = pick(32);
          st32 = 1'b1; md32 = m; a32 = a[31:0]; b32 = b[31:0];
          q32.push_back('{exp: model(32, m, a, b), t0: cyc + 1});
          @(negedge clk);
          st32 = 1'b0;
          k = 0;
          while (!done32 && k < 40) begin
            @(negedge clk);
            k++;
          end
          if (!done32) check_eq("timeout32", 128'd0, 128'd1);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check_eq("q32_drained", 128'(q32.size()), 128'd0);
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
